// File: rtl/elevator_call_panel.sv
// rtl/elevator_call_panel.sv - debounced call buttons with LED-acknowledged request pulses, retries and faults (optional FLOOR_DISPLAY_EN)
module elevator_call_panel #(
    parameter int DEB_CYCLES   = 4,
    parameter int ACK_TIMEOUT  = 8,
    parameter int MAX_RETRY    = 2,
    parameter int BLINK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] btn_raw,
    input  logic       fault_clr,
    input  logic       U1_led,
    input  logic       U2_led,
    input  logic       D2_led,
    input  logic       U3_led,
    input  logic       D3_led,
    input  logic       D4_led,
    input  logic       F1_led,
    input  logic       F2_led,
    input  logic       F3_led,
    input  logic       F4_led,
    output logic       U1,
    output logic       U2,
    output logic       D2,
    output logic       U3,
    output logic       D3,
    output logic       D4,
    output logic       F1,
    output logic       F2,
    output logic       F3,
    output logic       F4,
    output logic       busy,
    output logic [9:0] fault
`ifdef FLOOR_DISPLAY_EN
    ,
    input  logic [1:0] Floor,
    input  logic [1:0] Direction,
    input  logic       door_open,
    output logic [6:0] seg,
    output logic       up_ind,
    output logic       dn_ind
`endif
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {IDLE, PULSE, WAIT, LOCK} state_t;

    logic [9:0]    sync1_q, sync2_q;
    logic [9:0]    deb_q, deb_prev_q;
    logic [CW-1:0] deb_cnt_q [10];
    logic [9:0]    press;
    logic [9:0]    led;

    state_t        state_q [10];
    logic [TW-1:0] timer_q [10];
    logic [RW-1:0] retry_q [10];
    logic [9:0]    req_q;
    logic [9:0]    active_q;
    logic [9:0]    fault_q;

    assign led   = {F4_led, F3_led, F2_led, F1_led, D4_led, D3_led, U3_led, D2_led, U2_led, U1_led};
    assign press = deb_q & ~deb_prev_q;

    assign {F4, F3, F2, F1, D4, D3, U3, D2, U2, U1} = req_q;
    // active_q already holds each FSM's registered "not IDLE" flag
    assign busy  = |active_q;
    assign fault = fault_q;

    // Two-flop synchronizer for the asynchronous switch inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: level follows sync only after DEB_CYCLES consecutive differing cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 10; i++) deb_cnt_q[i] <= '0;
        end else begin
            deb_prev_q <= deb_q;
            for (int i = 0; i < 10; i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
                    deb_q[i]     <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Per-button request FSMs with registered pulse, activity and sticky fault outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q    <= '0;
            active_q <= '0;
            fault_q  <= '0;
            for (int i = 0; i < 10; i++) begin
                state_q[i] <= IDLE;
                timer_q[i] <= '0;
                retry_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 10; i++) begin
                req_q[i]   <= 1'b0;
                fault_q[i] <= fault_q[i] & ~fault_clr;
                case (state_q[i])
                    IDLE: begin
                        // A lit LED means the controller already holds this call
                        if (press[i] && !led[i]) begin
                            state_q[i]  <= PULSE;
                            retry_q[i]  <= '0;
                            req_q[i]    <= 1'b1;
                            active_q[i] <= 1'b1;
                        end else begin
                            active_q[i] <= 1'b0;
                        end
                    end
                    PULSE: begin
                        state_q[i] <= WAIT;
                        timer_q[i] <= '0;
                    end
                    WAIT: begin
                        if (led[i]) begin
                            state_q[i] <= LOCK;
                        end else if (timer_q[i] == TW'(ACK_TIMEOUT - 1)) begin
                            if (retry_q[i] < RW'(MAX_RETRY)) begin
                                retry_q[i] <= retry_q[i] + RW'(1);
                                state_q[i] <= PULSE;
                                req_q[i]   <= 1'b1;
                            end else begin
                                // Set is written after the clear so it wins a same-cycle fault_clr
                                fault_q[i]  <= 1'b1;
                                state_q[i]  <= IDLE;
                                active_q[i] <= 1'b0;
                            end
                        end else begin
                            timer_q[i] <= timer_q[i] + TW'(1);
                        end
                    end
                    LOCK: begin
                        if (!led[i]) begin
                            state_q[i]  <= IDLE;
                            active_q[i] <= 1'b0;
                        end
                    end
                    default: begin
                        state_q[i]  <= IDLE;
                        active_q[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef FLOOR_DISPLAY_EN
    localparam int BW = (BLINK_CYCLES < 2) ? 1 : $clog2(BLINK_CYCLES);

    logic [6:0]    seg_q;
    logic          up_q, dn_q, phase_q;
    logic [BW-1:0] blink_cnt_q;

    assign seg    = seg_q;
    assign up_ind = up_q;
    assign dn_ind = dn_q;

    // Floor digit decode (seg = {g,f,e,d,c,b,a}, active low) and direction blink
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q       <= 7'h7F;
            up_q        <= 1'b0;
            dn_q        <= 1'b0;
            phase_q     <= 1'b0;
            blink_cnt_q <= '0;
        end else begin
            case (Floor)
                2'd0:    seg_q <= 7'b1111001;
                2'd1:    seg_q <= 7'b0100100;
                2'd2:    seg_q <= 7'b0110000;
                default: seg_q <= 7'b0011001;
            endcase
            if (blink_cnt_q == BW'(BLINK_CYCLES - 1)) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BW'(1);
            end
            up_q <= (Direction == 2'b01) && (door_open || phase_q);
            dn_q <= (Direction == 2'b10) && (door_open || phase_q);
        end
    end
`endif

endmodule

// File: tb/tb_elevator_call_panel.sv
// tb/tb_elevator_call_panel.sv - self-checking bench for elevator_call_panel
module tb_elevator_call_panel;

    localparam int DEB   = 4;
    localparam int ACK   = 8;
    localparam int MAXR  = 2;
    localparam int BLINK = 16;
    localparam int P0    = DEB + 3;
    localparam int PMAX  = P0 + MAXR * (ACK + 1);
    localparam int FLTC  = PMAX + ACK + 1;
    localparam int NRUN  = 45;
    localparam int HELD  = 100000;
    localparam int NEVER = 100000;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] btn_raw;
    logic       fault_clr;
    logic [9:0] led_v;
    wire  [9:0] req_w;
    wire        busy;
    wire  [9:0] fault;
    logic [1:0] Floor;
    logic [1:0] Direction;
    logic       door_open;
`ifdef FLOOR_DISPLAY_EN
    wire  [6:0] seg;
    wire        up_ind;
    wire        dn_ind;
`endif

    int tests = 0;
    int fails = 0;

    logic [9:0] mask_v;
    int         w_a [10];
    int         l_a [10];
    int         r_a [10];

    always #5 clk = ~clk;

    elevator_call_panel #(
        .DEB_CYCLES(DEB), .ACK_TIMEOUT(ACK), .MAX_RETRY(MAXR), .BLINK_CYCLES(BLINK)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .fault_clr(fault_clr),
        .U1_led(led_v[0]), .U2_led(led_v[1]), .D2_led(led_v[2]), .U3_led(led_v[3]), .D3_led(led_v[4]),
        .D4_led(led_v[5]), .F1_led(led_v[6]), .F2_led(led_v[7]), .F3_led(led_v[8]), .F4_led(led_v[9]),
        .U1(req_w[0]), .U2(req_w[1]), .D2(req_w[2]), .U3(req_w[3]), .D3(req_w[4]),
        .D4(req_w[5]), .F1(req_w[6]), .F2(req_w[7]), .F3(req_w[8]), .F4(req_w[9]),
        .busy(busy), .fault(fault)
`ifdef FLOOR_DISPLAY_EN
        , .Floor(Floor), .Direction(Direction), .door_open(door_open),
        .seg(seg), .up_ind(up_ind), .dn_ind(dn_ind)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A button registers a press only if its raw high lasted at least DEB cycles
    function automatic bit pressed(input int i);
        return mask_v[i] && (w_a[i] >= DEB);
    endfunction

    // Pulses land at P0, P0+(ACK+1), ... up to MAXR retries, unless the LED came on first
    function automatic logic [9:0] exp_req(input int n);
        logic [9:0] v;
        int pk;
        v = '0;
        for (int i = 0; i < 10; i++) begin
            if (pressed(i)) begin
                for (int k = 0; k <= MAXR; k++) begin
                    pk = P0 + k * (ACK + 1);
                    if (n == pk && pk <= l_a[i]) v[i] = 1'b1;
                end
            end
        end
        return v;
    endfunction

    function automatic logic [9:0] exp_fault(input int n);
        logic [9:0] v;
        v = '0;
        for (int i = 0; i < 10; i++)
            if (pressed(i) && l_a[i] > PMAX + ACK && n >= FLTC) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic exp_busy(input int n);
        logic b;
        int   e;
        b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (pressed(i) && l_a[i] >= P0) begin
                e = (l_a[i] > PMAX + ACK) ? PMAX + ACK : r_a[i];
                if (n >= P0 && n <= e) b = 1'b1;
            end
        end
        return b;
    endfunction

    task automatic clear_model();
        mask_v = '0;
        for (int i = 0; i < 10; i++) begin
            w_a[i] = 0;
            l_a[i] = NEVER;
            r_a[i] = NEVER + 1;
        end
    endtask

    task automatic set_bit(input int i, input int w, input int l, input int r);
        mask_v[i] = 1'b1;
        w_a[i]    = w;
        l_a[i]    = l;
        r_a[i]    = r;
    endtask

    task automatic apply_inputs(input int n, input int fclr_cyc);
        for (int i = 0; i < 10; i++) begin
            btn_raw[i] = mask_v[i] && (n < w_a[i]);
            led_v[i]   = (n >= l_a[i]) && (n < r_a[i]);
        end
        fault_clr = (n == fclr_cyc);
    endtask

    task automatic run_scen(input string name, input int fclr_cyc);
        apply_inputs(0, fclr_cyc);
        for (int n = 1; n <= NRUN; n++) begin
            tick();
            chk($sformatf("%s req c%0d", name, n), req_w, exp_req(n));
            chk($sformatf("%s busy c%0d", name, n), busy, exp_busy(n));
            chk($sformatf("%s fault c%0d", name, n), fault, exp_fault(n));
            apply_inputs(n, fclr_cyc);
        end
        btn_raw   = '0;
        led_v     = '0;
        fault_clr = 1'b0;
        for (int n = 0; n < 12; n++) begin
            tick();
            chk($sformatf("%s idle req", name), req_w, 10'h000);
            chk($sformatf("%s idle fault", name), fault, exp_fault(NRUN));
        end
        chk($sformatf("%s idle busy", name), busy, 1'b0);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk($sformatf("%s fault_clr", name), fault, 10'h000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst       = 1'b1;
        btn_raw   = '0;
        fault_clr = 1'b0;
        led_v     = '0;
        Floor     = 2'b10;
        Direction = 2'b01;
        door_open = 1'b0;
        tick();
        tick();
        chk("reset req", req_w, 10'h000);
        chk("reset busy", busy, 1'b0);
        chk("reset fault", fault, 10'h000);
        rst = 1'b0;
        tick();
        tick();

        // Basic press on D3, acknowledged two cycles after the pulse
        clear_model();
        set_bit(4, HELD, P0 + 2, P0 + 7);
        run_scen("basic_d3", -1);

        // Already lit U2: no pulse, never busy
        clear_model();
        set_bit(1, HELD, 2, 30);
        run_scen("lit_u2", -1);

        // Retries to fault on F4 with fault_clr coinciding with the fault set
        clear_model();
        set_bit(9, HELD, NEVER, NEVER + 1);
        run_scen("retry_f4", FLTC - 1);

        // Mixed boundaries in one run
        clear_model();
        set_bit(0, DEB, NEVER, NEVER + 1);
        set_bit(2, DEB - 1, NEVER, NEVER + 1);
        set_bit(3, HELD, PMAX + ACK, PMAX + ACK + 5);
        set_bit(5, HELD, P0, P0 + 4);
        set_bit(8, HELD, P0 - 1, P0 + 3);
        set_bit(9, HELD, FLTC, FLTC + 3);
        run_scen("mixed", -1);

        // Randomized button sets, press widths and acknowledge times
        for (int s = 0; s < 6; s++) begin
            clear_model();
            mask_v = 10'($urandom_range(1, 1023));
            for (int i = 0; i < 10; i++) begin
                w_a[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * DEB)) : HELD;
                k = int'($urandom_range(0, 3));
                l_a[i] = (k == 0) ? NEVER : int'($urandom_range(P0 - 3, PMAX + ACK + 2));
                r_a[i] = l_a[i] + int'($urandom_range(3, 6));
            end
            run_scen($sformatf("rand%0d", s), -1);
        end

        // Bounce on F2: toggling every 2 cycles never settles
        clear_model();
        for (int n = 0; n < 34; n++) begin
            btn_raw[7] = (n < 20) && ((n / 2) % 2 == 0);
            tick();
            chk("bounce req", req_w, 10'h000);
            chk("bounce busy", busy, 1'b0);
        end
        chk("bounce fault", fault, 10'h000);

        // Simultaneous U1+F1, then reset while waiting for the acknowledge
        btn_raw = 10'h041;
        for (int n = 1; n <= 10; n++) begin
            tick();
            chk($sformatf("simul req c%0d", n), req_w, (n == P0) ? 10'h041 : 10'h000);
        end
        chk("simul busy in wait", busy, 1'b1);
        rst     = 1'b1;
        btn_raw = '0;
        tick();
        chk("midrst req", req_w, 10'h000);
        chk("midrst busy", busy, 1'b0);
        chk("midrst fault", fault, 10'h000);
        rst = 1'b0;
        for (int n = 0; n < 3 * (ACK + 1); n++) begin
            tick();
            chk("post rst req", req_w, 10'h000);
            chk("post rst busy", busy, 1'b0);
        end

`ifdef FLOOR_DISPLAY_EN
        chk("seg digit3", seg, 7'b0110000);
        chk("dn_ind idle", dn_ind, 1'b0);
        door_open = 1'b1;
        for (int n = 0; n < BLINK + 3; n++) begin
            tick();
            if (n >= 1) chk("up_ind door open", up_ind, 1'b1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/elevator_call_panel.md
Name: elevator_call_panel

Overview:
- Initiator side of the elevator request interface: turns raw, bouncy hall and car push-buttons into clean one-cycle request pulses on U1, U2, D2, U3, D3, D4, F1, F2, F3 and F4.
- Uses the controller's per-button LEDs as the acknowledge. A pulse that is not acknowledged is re-sent a bounded number of times, then a per-button fault bit is set.
- Sits between the board switches and the elevator controller, in the same clock domain.

Parameters:
- DEB_CYCLES, 4, consecutive stable cycles required before a debounced level changes (minimum 1).
- ACK_TIMEOUT, 8, cycles to wait for the LED after a pulse (minimum 2).
- MAX_RETRY, 2, extra pulses allowed before a fault is declared (0 allowed).
- BLINK_CYCLES, 16, half-period of the direction blink (used only with the optional feature).

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  10  raw buttons. Bit map: 0=U1, 1=U2, 2=D2, 3=U3, 4=D3, 5=D4, 6=F1, 7=F2, 8=F3, 9=F4.
- fault_clr  in  1  one-cycle pulse that clears all fault bits.
- U1_led, U2_led, D2_led, U3_led, D3_led, D4_led, F1_led, F2_led, F3_led, F4_led  in  1 each  acknowledge LEDs from the controller.
- U1, U2, D2, U3, D3, D4, F1, F2, F3, F4  out  1 each  registered request pulses to the controller.
- busy  out  1  high when any button FSM is not IDLE.
- fault  out  10  sticky per-button fault, same bit map as btn_raw.

Behaviour:
- Reset (rst=1 at a rising edge): synchronizers, debounced levels, counters, FSMs, request pulses, busy and fault all go to 0. A reset in mid-operation aborts pending retries, and no further pulse is issued.
- Synchronizer: 2-FF per bit; sync = btn_raw delayed by 2 cycles.
- Debounce, per bit:
  - The counter increments while sync differs from the debounced level and clears when they match.
  - When the count reaches DEB_CYCLES, the debounced level takes the sync value and the counter clears.
  - A glitch shorter than DEB_CYCLES never changes the debounced level.
- Press event: a rising edge of the debounced level, lasting one cycle. Falling edges are ignored.
- Per-button FSM (10 independent instances):
  - IDLE: on a press event with LED=0, go to PULSE with retry count = 0. On a press event with LED=1 (request already latched), stay in IDLE and issue nothing.
  - PULSE: the request output is 1 for exactly this one cycle. Go to WAIT; timer = 0.
  - WAIT: the request output is 0.
    - If LED=1, go to LOCK (LED takes priority over timeout in the same cycle).
    - Else if timer = ACK_TIMEOUT-1 and retry < MAX_RETRY: retry+1, go to PULSE.
    - Else if timer = ACK_TIMEOUT-1 (retries exhausted): set the fault bit, go to IDLE.
    - Otherwise timer+1.
  - LOCK: hold while LED=1; go to IDLE when LED=0 (request served).
  - Press events in PULSE, WAIT or LOCK are dropped.
- Latency: when btn_raw rises and is then held, the request pulse is high in cycle DEB_CYCLES+3, counted from the first sampling edge (edge 1).
- Simultaneous presses on different buttons each pulse in the same cycle. No arbitration is needed, because the controller accepts parallel requests.
- fault: a bit is set by a timeout and cleared only by fault_clr or rst. If set and fault_clr happen in the same cycle, set wins.
- busy: OR of (state != IDLE) across all ten FSMs, registered.

Optional Feature:
- Macro: FLOOR_DISPLAY_EN.
- When defined, the block adds:
  - Inputs Floor[2 bits], Direction[2 bits] and door_open.
  - Output seg[7 bits], active-low segments a–g showing digit Floor+1 (1–4), registered with 1-cycle latency.
  - Outputs up_ind and dn_ind. Direction 2'b01 = up, 2'b10 = down, any other value = idle.
  - The active indicator toggles every BLINK_CYCLES cycles while door_open=0, and is steady on while door_open=1. Both are 0 when idle.
  - Reset values: seg = 7'h7F (all segments off until the first update), up_ind = dn_ind = 0, blink counter = 0.
- When not defined, none of these ports or registers exist, and the rest of the behaviour is identical.

Test Plan:
- Basic press: DEB_CYCLES=4, btn_raw[4] (D3) held high from edge 0, D3_led driven to 1 two cycles after the pulse → D3=1 during cycle 7 only, FSM in LOCK, busy=1. D3_led falls → busy=0 the following cycle.
- Bounce rejection: btn_raw[7] toggles every 2 cycles for 20 cycles, then goes low → F2 never pulses, fault=0.
- Retry and fault: ACK_TIMEOUT=8, MAX_RETRY=2, F4 pressed with F4_led held 0 → exactly 3 F4 pulses spaced 9 cycles apart. Then fault[9]=1 and the FSM is in IDLE. A fault_clr pulse → fault=0.
- Already lit: U2_led=1 before the press, btn_raw[1] pressed → no U2 pulse, busy stays 0.
- Simultaneous presses and reset mid-wait: U1 and F1 pressed in the same cycle → both pulse in the same cycle. Assert rst during WAIT → all outputs 0 next cycle, no retry pulse follows.
- FLOOR_DISPLAY_EN: Floor=2'b10, Direction=2'b01, door_open=0, BLINK_CYCLES=16 → seg=7'b0110000 (digit 3) and up_ind toggles every 16 cycles. door_open=1 → up_ind held at 1.
